// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg
// Shared constants and types for the LED PWM brightness/breathing controller.
//   LED_PWM_NLED  : default number of LED channels
//   LED_PWM_CNT_W : default PWM counter / duty width (period = 2^CNT_W ticks)
//   LED_PWM_PRE_W : default prescaler width
//   breathe_dir_t : direction of a breathing channel's level ramp
package led_pwm_pkg;

  localparam int LED_PWM_NLED  = 4;
  localparam int LED_PWM_CNT_W = 8;
  localparam int LED_PWM_PRE_W = 16;

  typedef enum logic {DIR_UP, DIR_DOWN} breathe_dir_t;

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// led_pwm_ctrl_if
// Configuration bundle between the AXI-lite register file (master) and the
// LED PWM controller (slave).
//   cfg_prescale : ticks occur every cfg_prescale+1 clocks
//   cfg_duty     : per-channel duty (breathing ceiling when breathing)
//   cfg_breathe  : per-channel breathing enable
//   cfg_load     : single-cycle register write strobe capturing all cfg_*
//   cfg_pending  : high while a captured config waits for a period boundary
interface led_pwm_ctrl_if
  import led_pwm_pkg::*;
#(
  parameter int NLED  = LED_PWM_NLED,
  parameter int CNT_W = LED_PWM_CNT_W,
  parameter int PRE_W = LED_PWM_PRE_W
);

  logic [PRE_W-1:0]      cfg_prescale;
  logic [NLED*CNT_W-1:0] cfg_duty;
  logic [NLED-1:0]       cfg_breathe;
  logic                  cfg_load;
  logic                  cfg_pending;

  modport master (
    output cfg_prescale,
    output cfg_duty,
    output cfg_breathe,
    output cfg_load,
    input  cfg_pending
  );

  modport slave (
    input  cfg_prescale,
    input  cfg_duty,
    input  cfg_breathe,
    input  cfg_load,
    output cfg_pending
  );

endinterface

// File: rtl/led_pwm_chan.sv
// led_pwm_chan
// One LED channel: brightness level register, breathing direction FSM,
// PWM compare and the registered LED output.
//   axi_aclk, axi_areset : clock, asynchronous active-high reset
//   boundary             : PWM period boundary (counter wrap tick)
//   apply                : a new config becomes active at this boundary
//   breathe              : breathing enable that is in force for the next cycle
//   duty                 : duty (static) or ceiling (breathing) in force next
//   pwm_cnt              : shared PWM counter
//   led                  : registered LED drive
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int CNT_W = LED_PWM_CNT_W
) (
  input  logic             axi_aclk,
  input  logic             axi_areset,
  input  logic             boundary,
  input  logic             apply,
  input  logic             breathe,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] pwm_cnt,
  output logic             led
);

  localparam logic [CNT_W-1:0] LVL_MAX = '1;

  breathe_dir_t     dir_q, dir_d;
  logic [CNT_W-1:0] level_q, level_d;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      dir_q   <= DIR_UP;
      level_q <= '0;
      led     <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      level_q <= level_d;
      // Full-scale level means "always on", not 255/256 of the period.
      led     <= (pwm_cnt < level_q) || (level_q == LVL_MAX);
    end
  end

  // Static channels simply track the duty and park the direction at UP, so
  // switching breathing on later starts ramping up from the current level.
  // A newly applied ceiling below the current level clamps instead of stepping.
  // A DOWN direction sitting at level 0 (only possible after a clamp to 0
  // followed by a higher ceiling) turns around and climbs.
  always_comb begin
    level_d = level_q;
    dir_d   = dir_q;
    if (!breathe) begin
      level_d = duty;
      dir_d   = DIR_UP;
    end else if (apply && (duty < level_q)) begin
      level_d = duty;
      dir_d   = DIR_DOWN;
    end else if (boundary) begin
      if (duty == '0) begin
        level_d = '0;
        dir_d   = DIR_UP;
      end else if ((dir_q == DIR_UP) && (level_q < duty)) begin
        level_d = level_q + CNT_W'(1);
        dir_d   = (level_d == duty) ? DIR_DOWN : DIR_UP;
      end else if (level_q == '0) begin
        level_d = CNT_W'(1);
        dir_d   = (duty == CNT_W'(1)) ? DIR_DOWN : DIR_UP;
      end else begin
        level_d = level_q - CNT_W'(1);
        dir_d   = (level_d == '0) ? DIR_UP : DIR_DOWN;
      end
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl
// Per-LED PWM brightness and breathing controller. Configuration captured on
// cfg_load is held in pending registers and applied atomically at the next
// PWM period boundary so a period never mixes old and new settings.
//   axi_aclk, axi_areset : clock, asynchronous active-high reset
//   cfg                  : configuration bundle (slave side)
//   led                  : registered LED drive, one bit per channel
//   period_done          : one-cycle pulse after each PWM counter wrap
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int NLED  = LED_PWM_NLED,
  parameter int CNT_W = LED_PWM_CNT_W,
  parameter int PRE_W = LED_PWM_PRE_W
) (
  input  logic            axi_aclk,
  input  logic            axi_areset,
  led_pwm_ctrl_if.slave   cfg,
  output logic [NLED-1:0] led,
  output logic            period_done
);

  logic [PRE_W-1:0]      pre_cnt;
  logic [CNT_W-1:0]      pwm_cnt;
  logic [PRE_W-1:0]      prescale_act, prescale_pend, prescale_src;
  logic [NLED*CNT_W-1:0] duty_act, duty_pend, duty_src, duty_nxt;
  logic [NLED-1:0]       breathe_act, breathe_pend, breathe_src, breathe_nxt;
  logic                  pending_q;
  logic                  tick, boundary, apply;

  assign tick     = (pre_cnt == prescale_act);
  assign boundary = tick && (pwm_cnt == '1);
  assign apply    = boundary && (cfg.cfg_load || pending_q);

  // A load in the boundary cycle bypasses the pending registers entirely.
  always_comb begin
    prescale_src = prescale_pend;
    duty_src     = duty_pend;
    breathe_src  = breathe_pend;
    if (cfg.cfg_load) begin
      prescale_src = cfg.cfg_prescale;
      duty_src     = cfg.cfg_duty;
      breathe_src  = cfg.cfg_breathe;
    end
  end

  // Channels see the config that will be active from the next cycle on, so
  // their level updates on the same edge as the counter wrap.
  assign duty_nxt    = apply ? duty_src    : duty_act;
  assign breathe_nxt = apply ? breathe_src : breathe_act;

  assign cfg.cfg_pending = pending_q;

  // The boundary is always a tick, so pre_cnt already returns to zero when a
  // new config (possibly with a new prescale) is applied.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      pre_cnt       <= '0;
      pwm_cnt       <= '0;
      period_done   <= 1'b0;
      prescale_act  <= '0;
      duty_act      <= '0;
      breathe_act   <= '0;
      prescale_pend <= '0;
      duty_pend     <= '0;
      breathe_pend  <= '0;
      pending_q     <= 1'b0;
    end else begin
      pre_cnt     <= tick ? '0 : pre_cnt + PRE_W'(1);
      period_done <= boundary;
      if (tick) begin
        pwm_cnt <= pwm_cnt + CNT_W'(1);
      end
      if (apply) begin
        prescale_act <= prescale_src;
        duty_act     <= duty_src;
        breathe_act  <= breathe_src;
        pending_q    <= 1'b0;
      end else if (cfg.cfg_load) begin
        prescale_pend <= cfg.cfg_prescale;
        duty_pend     <= cfg.cfg_duty;
        breathe_pend  <= cfg.cfg_breathe;
        pending_q     <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NLED; i++) begin : g_chan
    led_pwm_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .axi_aclk   (axi_aclk),
      .axi_areset (axi_areset),
      .boundary   (boundary),
      .apply      (apply),
      .breathe    (breathe_nxt[i]),
      .duty       (duty_nxt[i*CNT_W +: CNT_W]),
      .pwm_cnt    (pwm_cnt),
      .led        (led[i])
    );
  end

endmodule
